// File: rtl/code_loader_pkg.sv
// Shared types and constants for the boot-time code loader.
// Imported by the loader FSM and its word assembler.
package code_loader_pkg;

  localparam int WORD_W         = 32;
  localparam int BYTES_PER_WORD = 4;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LEN_HI = 3'd1,
    S_LEN_LO = 3'd2,
    S_DATA   = 3'd3,
    S_WRITE  = 3'd4,
    S_DONE   = 3'd5,
    S_ERR    = 3'd6
  } state_e;

  // Byte address of word idx, wrapping modulo 2^32.
  function automatic logic [WORD_W-1:0] word_addr(
    input logic [WORD_W-1:0] base,
    input logic [15:0]       idx
  );
    return base + {14'd0, idx, 2'b00};
  endfunction

endpackage

// File: rtl/code_loader_word_assembler.sv
// Big-endian byte-to-word shift register with a byte counter.
// last flags that the next accepted byte completes the word.
module word_assembler
  import code_loader_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              en,
  input  logic [7:0]        byte_in,
  output logic [WORD_W-1:0] word,
  output logic              last
);

  localparam int CW = $clog2(BYTES_PER_WORD);

  logic [CW-1:0]     cnt_q, cnt_d;
  logic [WORD_W-1:0] sh_q, sh_d;

  always_comb begin
    cnt_d = cnt_q;
    sh_d  = sh_q;
    if (clr) begin
      cnt_d = '0;
      sh_d  = '0;
    end else if (en) begin
      cnt_d = cnt_q + CW'(1);
      sh_d  = {sh_q[WORD_W-9:0], byte_in};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
      sh_q  <= '0;
    end else begin
      cnt_q <= cnt_d;
      sh_q  <= sh_d;
    end
  end

  assign word = sh_q;
  assign last = (cnt_q == CW'(BYTES_PER_WORD - 1));

endmodule

// File: rtl/code_loader.sv
// Loads a length-prefixed big-endian image into code memory
// and holds the CPU in reset until the image is complete.
module code_loader
  import code_loader_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int unsigned DEPTH_WORDS = 256
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        byte_valid,
  input  logic [7:0]  byte_data,
  output logic        byte_ready,
  output logic        wr_en,
  output logic [31:0] wr_addr,
  output logic [31:0] wr_data,
  output logic        cpu_hold,
  output logic        done,
  output logic        err
);

  state_e      state_q, state_d;
  logic [15:0] idx_q, idx_d;
  logic [15:0] len_q, len_d;
  logic [7:0]  lenhi_q, lenhi_d;

  logic        byte_ready_q;
  logic        wr_en_q;
  logic [31:0] wr_addr_q;
  logic        cpu_hold_q;
  logic        done_q;
  logic        err_q;

  logic              xfer;
  logic              asm_clr;
  logic              asm_en;
  logic              asm_last;
  logic [WORD_W-1:0] asm_word;

  assign xfer = byte_valid && byte_ready_q;

  word_assembler u_asm (
    .clk     (clk),
    .rst     (rst),
    .clr     (asm_clr),
    .en      (asm_en),
    .byte_in (byte_data),
    .word    (asm_word),
    .last    (asm_last)
  );

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    len_d   = len_q;
    lenhi_d = lenhi_q;
    asm_clr = 1'b0;
    asm_en  = 1'b0;
    unique case (state_q)
      S_IDLE, S_DONE, S_ERR: begin
        if (start) begin
          state_d = S_LEN_HI;
          idx_d   = '0;
          asm_clr = 1'b1;
        end
      end
      S_LEN_HI: begin
        if (xfer) begin
          lenhi_d = byte_data;
          state_d = S_LEN_LO;
        end
      end
      S_LEN_LO: begin
        if (xfer) begin
          len_d = {lenhi_q, byte_data};
          if (len_d == 16'd0)
            state_d = S_DONE;
          else if ({16'd0, len_d} > DEPTH_WORDS)
            state_d = S_ERR;
          else
            state_d = S_DATA;
        end
      end
      S_DATA: begin
        if (xfer) begin
          asm_en = 1'b1;
          if (asm_last)
            state_d = S_WRITE;
        end
      end
      S_WRITE: begin
        idx_d   = idx_q + 16'd1;
        state_d = (idx_d == len_q) ? S_DONE : S_DATA;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs are registered from the next state so they line up
  // with the state they describe.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      idx_q        <= '0;
      len_q        <= '0;
      lenhi_q      <= '0;
      byte_ready_q <= 1'b0;
      wr_en_q      <= 1'b0;
      wr_addr_q    <= BASE_ADDR;
      cpu_hold_q   <= 1'b1;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      len_q        <= len_d;
      lenhi_q      <= lenhi_d;
      byte_ready_q <= (state_d == S_LEN_HI) ||
                      (state_d == S_LEN_LO) ||
                      (state_d == S_DATA);
      wr_en_q      <= (state_d == S_WRITE);
      cpu_hold_q   <= (state_d != S_DONE);
      done_q       <= (state_d == S_DONE);
      err_q        <= (state_d == S_ERR);
      if (state_d == S_WRITE)
        wr_addr_q <= word_addr(BASE_ADDR, idx_q);
      else if (asm_clr)
        wr_addr_q <= BASE_ADDR;
    end
  end

  assign byte_ready = byte_ready_q;
  assign wr_en      = wr_en_q;
  assign wr_addr    = wr_addr_q;
  assign wr_data    = asm_word;
  assign cpu_hold   = cpu_hold_q;
  assign done       = done_q;
  assign err        = err_q;

endmodule

// File: tb/tb_code_loader.sv
// Scoreboard bench for code_loader: directed images, expected
// writes queued by stimulus and checked by a write monitor.
module tb_code_loader;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;

  logic        clk;
  logic        rst;
  logic        start;
  logic        byte_valid;
  logic [7:0]  byte_data;
  logic        byte_ready;
  logic        wr_en;
  logic [31:0] wr_addr;
  logic [31:0] wr_data;
  logic        cpu_hold;
  logic        done;
  logic        err;

  int  checks = 0;
  int  errors = 0;
  wr_t exp_q[$];

  code_loader #(
    .BASE_ADDR   (32'h0000_0000),
    .DEPTH_WORDS (256)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .byte_valid (byte_valid),
    .byte_data  (byte_data),
    .byte_ready (byte_ready),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .cpu_hold   (cpu_hold),
    .done       (done),
    .err        (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // flags = {cpu_hold, byte_ready, done, err, wr_en}
  task automatic chk_flags(input string nm, input logic [4:0] exp);
    chk(nm, {27'd0, cpu_hold, byte_ready, done, err, wr_en},
        {27'd0, exp});
  endtask

  // Monitor: every write strobe must match the head of the queue.
  always @(posedge clk) begin
    wr_t e;
    #1;
    if (wr_en === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write: addr %h data %h",
                 wr_addr, wr_data);
      end else begin
        e = exp_q.pop_front();
        chk("wr_addr", wr_addr, e.addr);
        chk("wr_data", wr_data, e.data);
        chk("ready_in_write", {31'd0, byte_ready}, 32'd0);
      end
    end
  end

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic send(input logic [7:0] b, input int gap);
    int n;
    if (gap > 0) begin
      byte_valid = 1'b0;
      repeat (gap) @(negedge clk);
    end
    byte_valid = 1'b1;
    byte_data  = b;
    n = 0;
    while (byte_ready !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) begin
      checks++;
      errors++;
      $display("FAIL ready_timeout: got 0 expected 1");
    end
    @(negedge clk);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst        = 1'b1;
    start      = 1'b0;
    byte_valid = 1'b0;
    byte_data  = 8'h00;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk("reset_addr", wr_addr, 32'h0);
    chk("reset_data", wr_data, 32'h0);
    for (int i = 0; i < 20; i++) begin
      chk_flags("idle", 5'b10000);
      @(negedge clk);
    end

    // Two-word load
    pulse_start();
    exp_q.push_back('{32'h0, 32'h2008_0005});
    exp_q.push_back('{32'h4, 32'hAC08_0000});
    send(8'h00, 0); send(8'h02, 0);
    send(8'h20, 0); send(8'h08, 0);
    send(8'h00, 0); send(8'h05, 0);
    send(8'hAC, 0); send(8'h08, 0);
    send(8'h00, 0); send(8'h00, 0);
    byte_valid = 1'b0;
    chk_flags("two_word_write", 5'b10001);
    @(negedge clk);
    chk_flags("two_word_done", 5'b00100);

    // Restart from DONE: hold reasserts, done clears at once
    pulse_start();
    chk_flags("restart", 5'b11000);
    send(8'h00, 0); send(8'h00, 0);
    byte_valid = 1'b0;
    chk_flags("zero_len_done", 5'b00100);
    repeat (3) @(negedge clk);

    // Oversize length 257
    pulse_start();
    send(8'h01, 0); send(8'h01, 0);
    byte_valid = 1'b0;
    chk_flags("oversize_err", 5'b10010);
    repeat (5) @(negedge clk);
    chk_flags("oversize_hold", 5'b10010);

    // Backpressure, 3-cycle gaps
    pulse_start();
    exp_q.push_back('{32'h0, 32'hDEAD_BEEF});
    send(8'h00, 3); send(8'h01, 3);
    send(8'hDE, 3); send(8'hAD, 3); send(8'hBE, 3);
    chk_flags("bp_data_ready", 5'b11000);
    send(8'hEF, 3);
    byte_valid = 1'b0;
    chk_flags("bp_write", 5'b10001);
    @(negedge clk);
    chk_flags("bp_done", 5'b00100);

    // Reset mid-word
    pulse_start();
    send(8'h00, 0); send(8'h01, 0);
    send(8'hAA, 0); send(8'hBB, 0);
    byte_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk_flags("mid_reset_idle", 5'b10000);
    repeat (4) @(negedge clk);
    chk_flags("mid_reset_stay", 5'b10000);

    // Fresh image with an ignored start pulse in DATA
    pulse_start();
    exp_q.push_back('{32'h0, 32'h1122_3344});
    send(8'h00, 0); send(8'h01, 0);
    send(8'h11, 0); send(8'h22, 0);
    byte_valid = 1'b0;
    pulse_start();
    chk_flags("ignored_start", 5'b11000);
    send(8'h33, 0); send(8'h44, 0);
    byte_valid = 1'b0;
    chk_flags("fresh_write", 5'b10001);
    @(negedge clk);
    chk_flags("fresh_done", 5'b00100);

    repeat (5) @(negedge clk);
    chk("queue_empty", exp_q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
